text_pixel_gen: RTL and testbench

//  Text-mode pixel pipeline between VGA timing and the DAC. Per pixel clock: maps hCount/vCount
//  to a character cell, fetches code+attribute from char RAM, fetches the glyph row from the

---
 rtl/text_pixel_gen_if.sv | 36 +++
 rtl/text_pixel_gen.sv | 215 +++++++++++++++++++++
 tb/tb_text_pixel_gen.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_pixel_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : text_pixel_gen_if
//  Description : Memory-side bus of the text pixel pipeline. It carries the
//                character RAM read port and the font ROM read port. Both
//                memories return data one clock after the address is
//                presented.
//                  charRdAddr  12  char RAM address (row*COLS+col)
//                  charRdData  16  [7:0] code, [11:8] fg, [15:12] bg
//                  fontRdAddr  12  {code, glyphRow}
//                  fontRdData   8  glyph row, bit7 = leftmost pixel
//                master : pixel generator (drives addresses)
//                slave  : memory side (drives read data)
//  Revision    : 1.0  initial release
// ============================================================================
interface text_pixel_gen_if;
    logic [11:0] charRdAddr;
    logic [15:0] charRdData;
    logic [11:0] fontRdAddr;
    logic [7:0]  fontRdData;

    modport master (
        output charRdAddr,
        output fontRdAddr,
        input  charRdData,
        input  fontRdData
    );

    modport slave (
        input  charRdAddr,
        input  fontRdAddr,
        output charRdData,
        output fontRdData
    );
endinterface
`default_nettype wire

// File: rtl/text_pixel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : text_pixel_gen
//  Description : Text-mode pixel pipeline between VGA timing and the DAC.
//                Each pixel clock the current hCount/vCount is mapped to a
//                character cell, the cell's code/attribute is read from char
//                RAM, the glyph row is read from the font ROM and a 4-bit
//                colour index is produced. visIn/hsyncIn/vsyncIn are delayed
//                by the same 5 clocks so the output stays timing-aligned.
//  Ports       : clk, nrst (async, active low)
//                hCount/vCount[9:0], visIn, hsyncIn, vsyncIn  timing inputs
//                mem (text_pixel_gen_if.master)  char RAM / font ROM reads
//                pixColor[3:0], pixVis, hsyncOut, vsyncOut     outputs
//                cursorCol[6:0], cursorRow[4:0]  (TEXT_CURSOR_EN only)
//  Options     : define TEXT_CURSOR_EN to add a blinking underline cursor
//                (glyph rows 14/15 of the cursor cell forced to fg).
//  Revision    : 1.0  initial release
// ============================================================================
module text_pixel_gen #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [9:0]        hCount,
    input  logic [9:0]        vCount,
    input  logic              visIn,
    input  logic              hsyncIn,
    input  logic              vsyncIn,
`ifdef TEXT_CURSOR_EN
    input  logic [6:0]        cursorCol,
    input  logic [4:0]        cursorRow,
`endif
    text_pixel_gen_if.master  mem,
    output logic [3:0]        pixColor,
    output logic              pixVis,
    output logic              hsyncOut,
    output logic              vsyncOut
);

    // Address arithmetic is fixed at 12 bits; wider grids cannot be addressed.
    if (COLS * ROWS > 4096 || COLS > 128 || BLINK_FRAMES < 2) begin : g_paramCheck
        $error("text_pixel_gen: unsupported COLS/ROWS/BLINK_FRAMES");
    end

    localparam logic [11:0] c_COLS_VEC = 12'(COLS);

    // ------------------------------------------------------------------
    // Cell address: row*COLS built from shifted copies of the row for each
    // set bit of COLS (80 -> row<<6 + row<<4). Wraps mod 4096.
    // ------------------------------------------------------------------
    logic [5:0]  w_row;
    logic [6:0]  w_col;
    logic [11:0] w_rowMul;
    logic [11:0] w_cellAddr;

    assign w_row = vCount[9:4];
    assign w_col = hCount[9:3];

    always_comb begin
        w_rowMul = '0;
        for (int i = 0; i < 12; i++) begin
            if (c_COLS_VEC[i]) begin
                w_rowMul = w_rowMul + ({6'b0, w_row} << i);
            end
        end
    end

    assign w_cellAddr = w_rowMul + {5'b0, w_col};

    // ------------------------------------------------------------------
    // Pipeline registers (suffix = stage that loaded them)
    // ------------------------------------------------------------------
    logic [2:0] r_fineX1, r_fineX2, r_fineX3, r_fineX4;
    logic [3:0] r_glyphRow1, r_glyphRow2;
    logic       r_vis1, r_vis2, r_vis3, r_vis4;
    logic       r_hs1, r_hs2, r_hs3, r_hs4;
    logic       r_vs1, r_vs2, r_vs3, r_vs4;
    logic [3:0] r_fg3, r_fg4;
    logic [3:0] r_bg3, r_bg4;

    logic       w_pixBit;
    logic [3:0] w_color;

`ifdef TEXT_CURSOR_EN
    // ------------------------------------------------------------------
    // Cursor blink: count vsync falling edges, toggle every BLINK_FRAMES.
    // ------------------------------------------------------------------
    localparam int                 c_FRM_W    = $clog2(BLINK_FRAMES);
    localparam logic [c_FRM_W-1:0] c_FRM_LAST = c_FRM_W'(BLINK_FRAMES - 1);

    logic               r_vsPrev;
    logic [c_FRM_W-1:0] r_frameCnt;
    logic               r_cursorOn;
    logic               r_cur1, r_cur2, r_cur3, r_cur4;
    logic               w_cursorHit;

    // Underline occupies glyph rows 14 and 15 of the cursor cell.
    assign w_cursorHit = r_cursorOn && visIn
                      && (w_row == {1'b0, cursorRow})
                      && (w_col == cursorCol)
                      && (vCount[3:1] == 3'b111);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_vsPrev   <= 1'b1;
            r_frameCnt <= '0;
            r_cursorOn <= 1'b1;
            r_cur1     <= 1'b0;
            r_cur2     <= 1'b0;
            r_cur3     <= 1'b0;
            r_cur4     <= 1'b0;
        end else begin
            r_vsPrev <= vsyncIn;
            if (r_vsPrev && !vsyncIn) begin
                if (r_frameCnt == c_FRM_LAST) begin
                    r_frameCnt <= '0;
                    r_cursorOn <= ~r_cursorOn;
                end else begin
                    r_frameCnt <= r_frameCnt + 1'b1;
                end
            end
            r_cur1 <= w_cursorHit;
            r_cur2 <= r_cur1;
            r_cur3 <= r_cur2;
            r_cur4 <= r_cur3;
        end
    end
`endif

    // Final colour select; index ~fineX picks bit 7 for the leftmost pixel.
    always_comb begin
        w_pixBit = mem.fontRdData[~r_fineX4];
        w_color  = w_pixBit ? r_fg4 : r_bg4;
`ifdef TEXT_CURSOR_EN
        if (r_cur4) begin
            w_color = r_fg4;
        end
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mem.charRdAddr <= '0;
            mem.fontRdAddr <= '0;
            r_fineX1       <= '0;
            r_fineX2       <= '0;
            r_fineX3       <= '0;
            r_fineX4       <= '0;
            r_glyphRow1    <= '0;
            r_glyphRow2    <= '0;
            r_vis1         <= 1'b0;
            r_vis2         <= 1'b0;
            r_vis3         <= 1'b0;
            r_vis4         <= 1'b0;
            r_hs1          <= 1'b1;
            r_hs2          <= 1'b1;
            r_hs3          <= 1'b1;
            r_hs4          <= 1'b1;
            r_vs1          <= 1'b1;
            r_vs2          <= 1'b1;
            r_vs3          <= 1'b1;
            r_vs4          <= 1'b1;
            r_fg3          <= '0;
            r_fg4          <= '0;
            r_bg3          <= '0;
            r_bg4          <= '0;
            pixColor       <= '0;
            pixVis         <= 1'b0;
            hsyncOut       <= 1'b1;
            vsyncOut       <= 1'b1;
        end else begin
            // S1: cell address out to char RAM, carry pixel context
            mem.charRdAddr <= visIn ? w_cellAddr : 12'd0;
            r_fineX1       <= hCount[2:0];
            r_glyphRow1    <= vCount[3:0];
            r_vis1         <= visIn;
            r_hs1          <= hsyncIn;
            r_vs1          <= vsyncIn;

            // S2: char RAM is reading
            r_fineX2       <= r_fineX1;
            r_glyphRow2    <= r_glyphRow1;
            r_vis2         <= r_vis1;
            r_hs2          <= r_hs1;
            r_vs2          <= r_vs1;

            // S3: glyph row address out to font ROM, capture attributes
            mem.fontRdAddr <= {mem.charRdData[7:0], r_glyphRow2};
            r_fg3          <= mem.charRdData[11:8];
            r_bg3          <= mem.charRdData[15:12];
            r_fineX3       <= r_fineX2;
            r_vis3         <= r_vis2;
            r_hs3          <= r_hs2;
            r_vs3          <= r_vs2;

            // S4: font ROM is reading
            r_fineX4       <= r_fineX3;
            r_fg4          <= r_fg3;
            r_bg4          <= r_bg3;
            r_vis4         <= r_vis3;
            r_hs4          <= r_hs3;
            r_vs4          <= r_vs3;

            // S5: colour out; blanking forces index 0
            pixColor       <= r_vis4 ? w_color : 4'h0;
            pixVis         <= r_vis4;
            hsyncOut       <= r_hs4;
            vsyncOut       <= r_vs4;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_pixel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_pixel_gen
//  Description : Self-checking bench for text_pixel_gen. Holds char RAM and
//                font ROM models, drives one pixel per clock and predicts
//                addresses and outputs into scoreboard queues. Define
//                TEXT_CURSOR_EN to also exercise the blinking cursor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_text_pixel_gen;

    localparam int c_COLS  = 80;
    localparam int c_ROWS  = 30;
    localparam int c_BLINK = 30;

    typedef struct {
        int         due;
        logic [3:0] col;
        logic       vis;
        logic       hs;
        logic       vs;
    } pixExp_t;

    typedef struct {
        int          due;
        logic [11:0] addr;
    } addrExp_t;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic [9:0] hCount = '0;
    logic [9:0] vCount = '0;
    logic       visIn = 1'b0;
    logic       hsyncIn = 1'b1;
    logic       vsyncIn = 1'b1;
    logic [3:0] pixColor;
    logic       pixVis;
    logic       hsyncOut;
    logic       vsyncOut;
`ifdef TEXT_CURSOR_EN
    logic [6:0] cursorCol = 7'd3;
    logic [4:0] cursorRow = 5'd2;
    logic       mVsPrev = 1'b1;
    int         mFrm = 0;
    logic       mCursorOn = 1'b1;
`endif

    logic [15:0] charRam [4096];
    logic [7:0]  fontRom [4096];

    pixExp_t  qPix  [$];
    addrExp_t qChar [$];
    addrExp_t qFont [$];

    int cyc = 0;
    int vecCnt = 0;
    int errCnt = 0;

    text_pixel_gen_if bus ();

    text_pixel_gen #(
        .COLS         (c_COLS),
        .ROWS         (c_ROWS),
        .BLINK_FRAMES (c_BLINK)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .hCount    (hCount),
        .vCount    (vCount),
        .visIn     (visIn),
        .hsyncIn   (hsyncIn),
        .vsyncIn   (vsyncIn),
`ifdef TEXT_CURSOR_EN
        .cursorCol (cursorCol),
        .cursorRow (cursorRow),
`endif
        .mem       (bus),
        .pixColor  (pixColor),
        .pixVis    (pixVis),
        .hsyncOut  (hsyncOut),
        .vsyncOut  (vsyncOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Synchronous-read memories, one clock of latency.
    always @(posedge clk) begin
        bus.charRdData <= charRam[bus.charRdAddr];
        bus.fontRdData <= fontRom[bus.fontRdAddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Scoreboard comparison, sampled on the falling edge.
    always @(negedge clk) begin
        pixExp_t  pe;
        addrExp_t ae;
        if (nrst) begin
            if (qChar.size() > 0 && qChar[0].due == cyc) begin
                ae = qChar.pop_front();
                chk("charRdAddr", 32'(bus.charRdAddr), 32'(ae.addr));
            end
            if (qFont.size() > 0 && qFont[0].due == cyc) begin
                ae = qFont.pop_front();
                chk("fontRdAddr", 32'(bus.fontRdAddr), 32'(ae.addr));
            end
            if (qPix.size() > 0 && qPix[0].due == cyc) begin
                pe = qPix.pop_front();
                chk("pixColor", 32'(pixColor), 32'(pe.col));
                chk("pixVis",   32'(pixVis),   32'(pe.vis));
                chk("hsyncOut", 32'(hsyncOut), 32'(pe.hs));
                chk("vsyncOut", 32'(vsyncOut), 32'(pe.vs));
            end
        end
    end

    // Apply one pixel at the current falling edge, predict, advance a clock.
    task automatic px(input logic [9:0] h, input logic [9:0] v,
                      input logic vis, input logic hs, input logic vs);
        int          a;
        logic [11:0] cA;
        logic [15:0] attr;
        logic [7:0]  g;
        logic [3:0]  c;
        pixExp_t     pe;
        addrExp_t    ae;
        hCount  = h;
        vCount  = v;
        visIn   = vis;
        hsyncIn = hs;
        vsyncIn = vs;
        a    = int'(v[9:4]) * c_COLS + int'(h[9:3]);
        cA   = vis ? a[11:0] : 12'd0;
        attr = charRam[cA];
        g    = fontRom[{attr[7:0], v[3:0]}];
        c    = (g[7 - int'(h[2:0])]) ? attr[11:8] : attr[15:12];
`ifdef TEXT_CURSOR_EN
        if (mCursorOn && v[9:4] == {1'b0, cursorRow} && h[9:3] == cursorCol && v[3:1] == 3'b111)
            c = attr[11:8];
        if (mVsPrev && !vs) begin
            if (mFrm == c_BLINK - 1) begin
                mFrm = 0;
                mCursorOn = !mCursorOn;
            end else begin
                mFrm++;
            end
        end
        mVsPrev = vs;
`endif
        if (!vis) c = 4'h0;
        ae.due = cyc + 1; ae.addr = cA;                    qChar.push_back(ae);
        ae.due = cyc + 3; ae.addr = {attr[7:0], v[3:0]};   qFont.push_back(ae);
        pe.due = cyc + 5; pe.col = c; pe.vis = vis; pe.hs = hs; pe.vs = vs;
        qPix.push_back(pe);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    endtask

    // Asynchronous reset shortly after a rising edge, released on a falling
    // edge; the pipeline then shows reset values for 4 clocks.
    task automatic doReset(input bit doCheck);
        pixExp_t pe;
        #7;
        nrst = 1'b0;
        #1;
        if (doCheck) begin
            chk("rst pixColor",   32'(pixColor),       32'h0);
            chk("rst pixVis",     32'(pixVis),         32'h0);
            chk("rst hsyncOut",   32'(hsyncOut),       32'h1);
            chk("rst vsyncOut",   32'(vsyncOut),       32'h1);
            chk("rst charRdAddr", 32'(bus.charRdAddr), 32'h0);
            chk("rst fontRdAddr", 32'(bus.fontRdAddr), 32'h0);
        end
        qPix.delete();
        qChar.delete();
        qFont.delete();
`ifdef TEXT_CURSOR_EN
        mVsPrev = 1'b1;
        mFrm = 0;
        mCursorOn = 1'b1;
`endif
        @(negedge clk);
        @(negedge clk);
        hCount = '0; vCount = '0; visIn = 1'b0; hsyncIn = 1'b1; vsyncIn = 1'b1;
        nrst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            pe.due = cyc + i; pe.col = 4'h0; pe.vis = 1'b0; pe.hs = 1'b1; pe.vs = 1'b1;
            qPix.push_back(pe);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            charRam[i] = 16'($urandom);
            fontRom[i] = 8'($urandom);
        end
        charRam[0]      = 16'h1F41;
        fontRom[12'h410] = 8'h18;

        doReset(1'b1);

        // Cell (0,0): code 0x41, fg F, bg 1, glyph row 0x18
        for (int h = 0; h < 8; h++) px(10'(h), 10'd0, 1'b1, 1'b1, 1'b1);

        // Address corners, wrap and scattered visible pixels
        px(10'd639, 10'd479, 1'b1, 1'b1, 1'b1);
        px(10'd8,   10'd16,  1'b1, 1'b1, 1'b1);
        px(10'd1023, 10'd1023, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++)
            px(10'($urandom_range(639)), 10'($urandom_range(479)), 1'b1, 1'b1, 1'b1);

        // Blanking with an all-ones glyph under address 0, hsync pulse
        idle(6);
        for (int i = 0; i < 16; i++) fontRom[12'h410 + i] = 8'hFF;
        for (int i = 0; i < 10; i++)
            px(10'(100 + i), 10'd200, 1'b0, (i >= 3 && i < 6) ? 1'b0 : 1'b1, 1'b1);

        // Reset mid-frame while visible pixels with hsync low are in flight
        for (int i = 0; i < 8; i++) px(10'(16 + i), 10'd40, 1'b1, 1'b0, 1'b1);
        doReset(1'b1);

        // Reset mid-line at hCount=300, resume right after release
        for (int h = 290; h <= 300; h++) px(10'(h), 10'd100, 1'b1, 1'b1, 1'b1);
        doReset(1'b1);
        for (int h = 301; h <= 320; h++) px(10'(h), 10'd100, 1'b1, 1'b1, 1'b1);

`ifdef TEXT_CURSOR_EN
        // Cursor cell (row 2, col 3): blank glyph, fg 7, bg 2
        idle(6);
        charRam[2 * c_COLS + 3] = 16'h27C3;
        for (int i = 0; i < 16; i++) fontRom[12'hC30 + i] = 8'h00;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < c_BLINK; k++) begin
                if (r > 0) begin
                    px(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
                    px(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
                end
            end
            for (int v = 45; v <= 47; v++)
                for (int h = 24; h < 32; h++) px(10'(h), 10'(v), 1'b1, 1'b1, 1'b1);
        end
`endif

        idle(6);
        for (int i = 0; i < 20 && (qPix.size() + qChar.size() + qFont.size()) > 0; i++)
            @(negedge clk);
        chk("drain", 32'(qPix.size() + qChar.size() + qFont.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
`default_nettype wire
